// File: rtl/adder_pkg.sv
// Shared sizing for the pipelined adder: default width, depth and chunk split.
package adder_pkg;

    localparam int unsigned DEF_N      = 16;
    localparam int unsigned DEF_STAGES = 4;

    // Bits of the operand added by each pipeline stage.
    function automatic int unsigned chunk_width(input int unsigned n, input int unsigned stages);
        return n / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline slot: adds chunk K of the operands with the carry from the
// previous slot, and holds the operation until the next slot can take it.
module adder_stage
    import adder_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = chunk_width(DEF_N, DEF_STAGES),
    parameter int unsigned K = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    // upstream side
    input  logic         i_valid,
    output logic         o_ready_c,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_sum,
    input  logic         i_carry,
    // downstream side
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_b,
    output logic [N-1:0] o_sum,
    output logic         o_carry,
    output logic         o_ovf
);

    localparam int unsigned LO = K * W;

    logic         r_valid;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_sum;
    logic         r_carry;
    logic         r_ovf;

    logic [W:0]   w_chunk;
    logic [N-1:0] w_sum_next;
    logic         w_ovf;
    logic         w_load;

    // Chunk add, splice into the partial sum, and overflow from the top bits
    // (only meaningful once the top chunk has been added in the last slot).
    always_comb begin
        w_chunk    = {1'b0, i_a[LO +: W]} + {1'b0, i_b[LO +: W]} + (W+1)'(i_carry);
        w_sum_next = i_sum;
        w_sum_next[LO +: W] = w_chunk[W-1:0];
        w_ovf      = (i_a[N-1] == i_b[N-1]) && (w_sum_next[N-1] != i_a[N-1]);
    end

    // Slot can take new work when empty or when its content leaves this cycle.
    assign o_ready_c = !r_valid || i_ready;
    assign w_load    = i_valid && o_ready_c;

    // Slot registers; data only changes when a new operation lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (o_ready_c) begin
                r_valid <= i_valid;
            end
            if (w_load) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_sum   <= w_sum_next;
                r_carry <= w_chunk[W];
                r_ovf   <= w_ovf;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_sum   = r_sum;
    assign o_carry = r_carry;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/subtract split into STAGES carry-registered chunks with a
// valid/ready handshake on both ends and a combinational ready chain.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    // N must divide evenly by STAGES; each slot handles W bits.
    localparam int unsigned W = chunk_width(N, STAGES);

    logic [N-1:0] w_a     [STAGES+1];
    logic [N-1:0] w_b     [STAGES+1];
    logic [N-1:0] w_sum   [STAGES+1];
    logic         w_carry [STAGES+1];
    logic         w_valid [STAGES+1];
    logic         w_ready [STAGES+1];
    logic         w_ovf   [1:STAGES];

    // Subtract folds into the operation at entry: invert b, force carry-in.
    assign w_a[0]     = a;
    assign w_b[0]     = sub ? ~b : b;
    assign w_sum[0]   = '0;
    assign w_carry[0] = sub ? 1'b1 : cin;
    assign w_valid[0] = in_valid;
    assign w_ready[STAGES] = out_ready;

    // Slot chain, chunk k handled by slot k.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .N (N),
            .W (W),
            .K (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_valid   (w_valid[k]),
            .o_ready_c (w_ready[k]),
            .i_a       (w_a[k]),
            .i_b       (w_b[k]),
            .i_sum     (w_sum[k]),
            .i_carry   (w_carry[k]),
            .o_valid   (w_valid[k+1]),
            .i_ready   (w_ready[k+1]),
            .o_a       (w_a[k+1]),
            .o_b       (w_b[k+1]),
            .o_sum     (w_sum[k+1]),
            .o_carry   (w_carry[k+1]),
            .o_ovf     (w_ovf[k+1])
        );
    end

    // Hold off upstream while reset is asserted.
    assign in_ready  = rst_n && w_ready[0];
    assign out_valid = w_valid[STAGES];
    assign sum       = w_sum[STAGES];
    assign cout      = w_carry[STAGES];
    assign ovf       = w_ovf[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed + random bench for pipelined_adder (N=16, STAGES=4) with a
// queue scoreboard filled on input transfers and drained on output transfers.
module tb_pipelined_adder;

    localparam int unsigned N      = 16;
    localparam int unsigned STAGES = 4;

    typedef logic [N+1:0] exp_t; // {cout, ovf, sum}

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   sb_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_cyc = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   last_lat = 0;
    bit   acc_flag;
    bit   out_flag;
    bit   chk_lat = 1'b0;
    exp_t pend_exp;

    // Reference arithmetic.
    function automatic exp_t model(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                   input logic fcin, input logic fsub);
        logic [N-1:0] be;
        logic [N:0]   r;
        logic         v;
        be = fsub ? ~fb : fb;
        r  = {1'b0, fa} + {1'b0, be} + (N+1)'(fsub ? 1'b1 : fcin);
        v  = (fa[N-1] == be[N-1]) && (r[N-1] != fa[N-1]);
        return {r[N], v, r[N-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then advance past rising edge.
    task automatic step();
        exp_t e;
        int   c;
        acc_flag = 1'b0;
        out_flag = 1'b0;
        @(negedge clk);
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back(pend_exp);
            sb_cyc.push_back(n_cyc);
            n_acc++;
            acc_flag = 1'b1;
        end
        if (out_valid && out_ready) begin
            out_flag = 1'b1;
            n_out++;
            n_cmp++;
            assert (sb_q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_out: observed sum %0h with nothing expected", sum);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                c = sb_cyc.pop_front();
                last_lat = n_cyc - c;
                check("result", 32'({cout, ovf, sum}), 32'(e));
                if (chk_lat) check("latency", 32'(last_lat), STAGES);
            end
        end else if (out_valid && sb_q.size() != 0) begin
            check("held_output", 32'({cout, ovf, sum}), 32'(sb_q[0]));
        end
        @(posedge clk);
        #1;
        n_cyc++;
    endtask

    // Present one operation until accepted; in_valid stays high on return.
    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tcin,
                        input logic tsub, input exp_t texp, input bit rnd_ready);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        pend_exp = texp;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            if (acc_flag) break;
        end
        check("send_accepted", 32'(acc_flag), 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (sb_q.size() == 0) break;
            step();
        end
        check("drain_empty", 32'(sb_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc;
        int base_out;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic         rs;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum",       32'(sum),       0);
        check("rst_cout",      32'(cout),      0);
        check("rst_ovf",       32'(ovf),       0);

        rst_n = 1'b1;
        #1;
        check("in_ready_after_release", 32'(in_ready), 1);

        // Single op with out_ready held high: wraps to zero with carry out.
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, 1'b0);
        drain();

        // Back-to-back directed ops, full throughput.
        base_out = n_out;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, 1'b0);
        send(16'h1234, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1235}, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000}, 1'b0);
        drain();
        check("directed_count", 32'(n_out - base_out), 5);
        chk_lat = 1'b0;

        // Fill the pipe with out_ready low, then release.
        out_ready = 1'b0;
        base_acc  = n_acc;
        base_out  = n_out;
        for (int i = 0; i < 4; i++) begin
            ra = 16'(i + 1) * 16'h1111;
            send(ra, 16'h0101, 1'(i), 1'b0, model(ra, 16'h0101, 1'(i), 1'b0), 1'b0);
        end
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
        pend_exp = model(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        in_valid = 1'b1;
        repeat (3) step();
        check("full_accepted",  32'(n_acc - base_acc), 4);
        check("full_in_ready",  32'(in_ready), 0);
        check("full_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        check("fifth_same_cycle", 32'(acc_flag), 1);
        check("first_out",        32'(out_flag), 1);
        in_valid = 1'b0;
        repeat (3) begin
            step();
            check("consecutive_out", 32'(out_flag), 1);
        end
        check("full_out_count", 32'(n_out - base_out), 4);
        drain();
        check("full_total", 32'(n_out - base_out), 5);

        // Random back-to-back traffic with random downstream stalls.
        base_out = n_out;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
        end
        drain();
        check("random_count", 32'(n_out - base_out), 100);

        // Reset with three ops in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = 16'(i) + 16'h0100;
            send(ra, 16'h0010, 1'b0, 1'b0, model(ra, 16'h0010, 1'b0, 1'b0), 1'b0);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready",  32'(in_ready),  0);
        check("midrst_sum",       32'(sum),       0);
        sb_q.delete();
        sb_cyc.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        base_out  = n_out;
        repeat (10) step();
        check("no_out_after_reset", 32'(n_out - base_out), 0);
        send(16'h0001, 16'h0002, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0003}, 1'b0);
        drain();
        check("post_reset_count", 32'(n_out - base_out), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
